// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: one-cycle cpu_en pulse generator for the single-cycle CPU (halt / free-run / single-step / run-to-breakpoint).
// Latency: first free-run pulse div+1 cycles after RUN entry; button press to pulse is 2 + DEBOUNCE_CYC + 3 cycles.
// Backpressure: none; the CPU takes every pulse, and step requests that arrive in a state that cannot use them are dropped.
//
// Ports:
//   clk_100MHz  board clock, the only clock
//   rst         asynchronous active-low reset
//   mode        00 halt, 01 free-run, 10 single-step, 11 run-to-breakpoint
//   div         free-run period is div+1 cycles
//   step_btn    raw asynchronous push button, active high
//   bp_addr/PC  breakpoint address and current CPU PC
//   cpu_en      registered one-cycle enable pulse
//   halted      registered, 1 while the controller sits in IDLE or BREAK
//   step_cnt    registered count of issued pulses
// Build option: define CPU_STEP_CNT_EN to build the pulse counter; without it step_cnt is tied to zero.

module cpu_step_ctrl #(
    parameter int DIV_W        = 24,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int PC_W         = 32
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             step_btn,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  PC,
    output logic             cpu_en,
    output logic             halted,
    output logic [31:0]      step_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_BRK  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button path: synchroniser, debounce, rising-edge detect
    // ------------------------------------------------------------------
    logic            btn_meta_q, btn_meta_d;
    logic            btn_sync_q, btn_sync_d;
    logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic            db_lvl_q,   db_lvl_d;
    logic            db_prev_q,  db_prev_d;
    logic            step_req_q, step_req_d;

    always_comb begin
        btn_meta_d = step_btn;
        btn_sync_d = btn_meta_q;
        db_cnt_d   = '0;
        db_lvl_d   = db_lvl_q;
        // The counter only runs while the synchronised level disagrees with
        // the debounced level; any agreement restarts the stability window.
        if (btn_sync_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = ~db_lvl_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        db_prev_d  = db_lvl_q;
        step_req_d = db_lvl_q & ~db_prev_q;
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_cnt_q   <= '0;
            db_lvl_q   <= 1'b0;
            db_prev_q  <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            db_prev_q  <= db_prev_d;
            step_req_q <= step_req_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic             halted_q, halted_d;

    logic run_mode;
    logic bp_hit;
    logic div_hit;

    assign run_mode = (mode == MODE_FREE) || (mode == MODE_BRK);
    assign bp_hit   = (mode == MODE_BRK) && (PC == bp_addr);
    // >= rather than == so a div lowered below the running count fires at once.
    assign div_hit  = (div_cnt_q >= div);

    // State register
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_mode) begin
                    state_d = S_RUN;
                end else if ((mode == MODE_STEP) && step_req_q) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_mode) begin
                    state_d = S_IDLE;
                end else if (bp_hit) begin
                    state_d = S_BREAK;
                end
            end
            S_STEP: begin
                state_d = (mode == MODE_BRK) ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                if (step_req_q) begin
                    state_d = S_STEP;
                end else if (mode != MODE_BRK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: pulse and divider decisions, registered below
    always_comb begin
        cpu_en_d  = 1'b0;
        div_cnt_d = '0;
        halted_d  = (state_q == S_IDLE) || (state_q == S_BREAK);
        unique case (state_q)
            S_RUN: begin
                // A breakpoint match suppresses the pulse due this cycle, and
                // a mode leaving free-run stops pulses straight away.
                if (run_mode && !bp_hit) begin
                    if (div_hit) begin
                        cpu_en_d = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
            end
            S_STEP: begin
                cpu_en_d = 1'b1;
            end
            default: begin
                cpu_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            cpu_en_q  <= 1'b0;
            halted_q  <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            cpu_en_q  <= cpu_en_d;
            halted_q  <= halted_d;
        end
    end

    assign cpu_en = cpu_en_q;
    assign halted = halted_q;

    // ------------------------------------------------------------------
    // Pulse counter
    // ------------------------------------------------------------------
`ifdef CPU_STEP_CNT_EN
    logic [31:0] step_cnt_q, step_cnt_d;

    // Wraps naturally at 2^32-1.
    always_comb begin
        step_cnt_d = step_cnt_q + {31'd0, cpu_en_q};
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            step_cnt_q <= 32'd0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and randomized checks of cpu_step_ctrl with DEBOUNCE_CYC=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cpu_step_ctrl;

    localparam int DIV_W = 24;
    localparam int PC_W  = 32;

    logic             clk_100MHz = 1'b0;
    logic             rst        = 1'b0;
    logic [1:0]       mode       = 2'b00;
    logic [DIV_W-1:0] div        = '0;
    logic             step_btn   = 1'b0;
    logic [PC_W-1:0]  bp_addr    = '0;
    logic [PC_W-1:0]  PC         = '0;
    logic             cpu_en;
    logic             halted;
    logic [31:0]      step_cnt;

    int total   = 0;
    int bad     = 0;
    int exp_cnt = 0;   // pulses seen at earlier samples; step_cnt lags cpu_en by one edge
    int n_pulse = 0;
    bit pc_follow = 1'b1;

    cpu_step_ctrl #(
        .DIV_W(DIV_W),
        .DEBOUNCE_CYC(4),
        .PC_W(PC_W)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .mode(mode),
        .div(div),
        .step_btn(step_btn),
        .bp_addr(bp_addr),
        .PC(PC),
        .cpu_en(cpu_en),
        .halted(halted),
        .step_cnt(step_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1ns after the edge, check the counter, then let the
    // CPU model advance its PC on each observed pulse.
    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
`ifdef CPU_STEP_CNT_EN
        chk("step_cnt", step_cnt, 32'(exp_cnt));
`else
        chk("step_cnt_tied", step_cnt, 32'd0);
`endif
        if (cpu_en === 1'b1) begin
            exp_cnt++;
            n_pulse++;
            if (pc_follow) PC = PC + 32'd4;
        end
    endtask

    // Reset mid-cycle, load new settings, release mid-cycle before the next edge.
    task automatic do_reset(input logic [1:0] m, input int d, input logic [PC_W-1:0] bp);
        rst      = 1'b0;
        #1;
        PC       = '0;
        exp_cnt  = 0;
        step_btn = 1'b0;
        mode     = m;
        div      = DIV_W'(d);
        bp_addr  = bp;
        cyc();
        cyc();
        #3;
        rst = 1'b1;
    endtask

    // Free-run from IDLE: the n-th sample after entry edge is a pulse when
    // (n-1) is a nonzero multiple of the period div+1.
    task automatic run_free(input string tag, input int d, input int n);
        for (int k = 1; k <= n; k++) begin
            cyc();
            chk(tag, 32'(cpu_en), ((k > 1) && ((k - 1) % (d + 1) == 0)) ? 32'd1 : 32'd0);
        end
    endtask

    // Press (or glitch) the button for 'hold' samples, then watch 'n' samples.
    // Expect a pulse only at sample 'pulse_at' (0 = never).
    task automatic press(input string tag, input int hold, input int n, input int pulse_at);
        step_btn = 1'b1;
        for (int k = 1; k <= n; k++) begin
            cyc();
            chk(tag, 32'(cpu_en), (k == pulse_at) ? 32'd1 : 32'd0);
            if (k == hold) step_btn = 1'b0;
        end
    endtask

    initial begin
        int d;
        int kbp;
        int np0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_step_cnt", step_cnt, 32'd0);

        // ---------------- free-run div=3 ----------------
        mode = 2'b01;
        div  = DIV_W'(3);
        rst  = 1'b1;
        np0  = n_pulse;
        run_free("free_d3", 3, 41);
        chk("free_d3_pulses", 32'(n_pulse - np0), 32'd10);
        chk("free_halted", 32'(halted), 32'd0);

        // div lowered to 0 right after a pulse: continuous enable
        div = '0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("free_d0", 32'(cpu_en), 32'd1);
        end

        // ---------------- async reset mid-pulse ----------------
        #3;
        rst = 1'b0;
        #1;
        chk("arst_cpu_en", 32'(cpu_en), 32'd0);
        chk("arst_halted", 32'(halted), 32'd1);
        chk("arst_step_cnt", step_cnt, 32'd0);
        exp_cnt = 0;
        mode = 2'b01;
        div  = DIV_W'(3);
        cyc();
        cyc();
        #3;
        rst = 1'b1;
        run_free("rst_release", 3, 9);

        // ---------------- div lowered mid-count ----------------
        mode = 2'b00;
        cyc();
        cyc();
        chk("halt_cpu_en", 32'(cpu_en), 32'd0);
        div  = DIV_W'(7);
        mode = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            chk("div_change", 32'(cpu_en), (k == 5 || k == 8 || k == 11) ? 32'd1 : 32'd0);
            if (k == 4) div = DIV_W'(2);
        end

        // ---------------- single-step ----------------
        mode = 2'b10;
        cyc();
        cyc();
        cyc();
        chk("step_idle_halted", 32'(halted), 32'd1);
        // 3-cycle glitch: shorter than the debounce window
        step_btn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("glitch_cpu_en", 32'(cpu_en), 32'd0);
            chk("glitch_halted", 32'(halted), 32'd1);
            if (k == 3) step_btn = 1'b0;
        end
        // Held press: one pulse at 2+4+1+1+1 = 9 samples
        np0 = n_pulse;
        press("step_pulse", 10, 22, 9);
        chk("step_pulses", 32'(n_pulse - np0), 32'd1);
        chk("step_halted", 32'(halted), 32'd1);

        // ---------------- run-to-breakpoint ----------------
        do_reset(2'b11, 0, 32'h0C);
        np0 = n_pulse;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("bp_run", 32'(cpu_en), (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
        end
        chk("bp_pulses", 32'(n_pulse - np0), 32'd3);
        chk("bp_pc", PC, 32'h0C);
        chk("bp_halted", 32'(halted), 32'd1);
        np0 = n_pulse;
        press("bp_step", 10, 22, 9);
        chk("bp_step_pulses", 32'(n_pulse - np0), 32'd1);
        chk("bp_step_pc", PC, 32'h10);
        chk("bp_step_halted", 32'(halted), 32'd1);
        // BREAK -> IDLE -> RUN, free-run resumes with div=0
        mode = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("bp_resume", 32'(cpu_en), (k >= 3) ? 32'd1 : 32'd0);
        end

        // ---------------- breakpoint and divider hit together ----------------
        do_reset(2'b11, 3, 32'h08);
        pc_follow = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("simul_cpu_en", 32'(cpu_en), 32'd0);
            if (k == 4) PC = 32'h08;
        end
        chk("simul_halted", 32'(halted), 32'd1);
        pc_follow = 1'b1;

        // ---------------- randomized free-run ----------------
        for (int it = 0; it < 4; it++) begin
            d = int'($urandom_range(9, 0));
            do_reset(2'b01, d, 32'hFFFF_FFF0);
            np0 = n_pulse;
            run_free("rnd_free", d, 30);
            chk("rnd_free_pulses", 32'(n_pulse - np0), 32'(29 / (d + 1)));
        end

        // ---------------- randomized breakpoint ----------------
        for (int it = 0; it < 6; it++) begin
            d   = int'($urandom_range(3, 0));
            kbp = int'($urandom_range(5, 0));
            do_reset(2'b11, d, 32'(4 * kbp));
            np0 = n_pulse;
            for (int s = 1; s <= (kbp + 1) * (d + 1) + 6; s++) begin
                cyc();
                chk("rnd_bp_cpu_en", 32'(cpu_en),
                    ((s > 1) && ((s - 1) % (d + 1) == 0) && ((s - 1) / (d + 1) <= kbp)) ? 32'd1 : 32'd0);
            end
            chk("rnd_bp_pulses", 32'(n_pulse - np0), 32'(kbp));
            chk("rnd_bp_pc", PC, 32'(4 * kbp));
            chk("rnd_bp_halted", 32'(halted), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
